// File: rtl/logic_op_arbiter.sv
// logic_op_arbiter
// Four requesters compete for a single bitwise-logic unit. A round-robin
// arbiter picks one requester in IDLE and latches its opcode and operands.
// The unit computes the result in EXEC and holds it in DONE until the
// consumer accepts it. The round-robin pointer then moves past the served
// requester, so every active requester gets a turn.
//
// Ports
//   clk        rising-edge clock for all state
//   rst_n      asynchronous active-low reset
//   req[3:0]   per-requester request, held with operands until its grant
//   op[7:0]    2-bit opcode per requester (op[2i+1:2i] for requester i)
//   a_in, b_in W-bit operands per requester, packed by requester index
//   gnt[3:0]   one-hot grant, high for one cycle per accepted request
//   res_valid  result available
//   res_id     requester that owns the current/last result
//   res_data   registered W-bit result
//   res_ready  consumer accepts the result while res_valid is high
//   busy       high whenever the unit is not idle
//   done_cnt   number of results accepted by the consumer, wraps at 256
module logic_op_arbiter #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [3:0]     req,
  input  logic [7:0]     op,
  input  logic [4*W-1:0] a_in,
  input  logic [4*W-1:0] b_in,
  output logic [3:0]     gnt,
  output logic           res_valid,
  output logic [1:0]     res_id,
  output logic [W-1:0]   res_data,
  input  logic           res_ready,
  output logic           busy,
  output logic [7:0]     done_cnt
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t         state;
  logic [1:0]     ptr;
  logic [1:0]     winner;
  logic [1:0]     cand;
  logic           found;
  logic [1:0]     win_op;
  logic [W-1:0]   win_a;
  logic [W-1:0]   win_b;
  logic [1:0]     lat_op;
  logic [W-1:0]   lat_a;
  logic [W-1:0]   lat_b;
  logic [W-1:0]   op_result;

  // Round-robin search: the first active request at or after ptr wins.
  always_comb begin
    winner = ptr;
    found  = 1'b0;
    cand   = ptr;
    for (int k = 0; k < 4; k++) begin
      cand = ptr + 2'(k);
      if (!found && req[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  // Steer the winner's opcode and operands towards the latch.
  always_comb begin
    win_op = 2'b00;
    win_a  = '0;
    win_b  = '0;
    for (int i = 0; i < 4; i++) begin
      if (winner == 2'(i)) begin
        win_op = op[2*i +: 2];
        win_a  = a_in[i*W +: W];
        win_b  = b_in[i*W +: W];
      end
    end
  end

  // Bitwise operation on the latched operands. Inputs may change after the
  // grant without disturbing this result.
  always_comb begin
    case (lat_op)
      2'b00:   op_result = ~lat_a;
      2'b01:   op_result = lat_a & lat_b;
      2'b10:   op_result = lat_a | lat_b;
      default: op_result = lat_a ^ lat_b;
    endcase
  end

  // Control FSM with registered outputs. res_id and res_data keep their last
  // values through IDLE, so a late observer still sees the previous result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= 2'd0;
      gnt       <= 4'b0000;
      res_valid <= 1'b0;
      res_id    <= 2'd0;
      res_data  <= '0;
      done_cnt  <= 8'd0;
      lat_op    <= 2'b00;
      lat_a     <= '0;
      lat_b     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req != 4'b0000) begin
            gnt    <= 4'b0001 << winner;
            res_id <= winner;
            lat_op <= win_op;
            lat_a  <= win_a;
            lat_b  <= win_b;
            state  <= EXEC;
          end else begin
            gnt <= 4'b0000;
          end
        end
        EXEC: begin
          gnt       <= 4'b0000;
          res_data  <= op_result;
          res_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            ptr       <= res_id + 2'd1;
            done_cnt  <= done_cnt + 8'd1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_logic_op_arbiter.sv
// tb_logic_op_arbiter
// Self-checking bench for logic_op_arbiter: directed scenarios plus a
// randomized run checked against a cycle-level behavioural model.
module tb_logic_op_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [7:0]  op;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic [3:0]  gnt;
  logic        res_valid;
  logic [1:0]  res_id;
  logic [7:0]  res_data;
  logic        res_ready;
  logic        busy;
  logic [7:0]  done_cnt;

  int total = 0;
  int bad   = 0;

  // Behavioural model state (phase 0 = waiting, 1 = computing, 2 = holding)
  int          m_phase;
  logic [1:0]  m_ptr;
  logic [1:0]  m_id;
  logic [1:0]  m_lop;
  logic [7:0]  m_la;
  logic [7:0]  m_lb;
  logic [7:0]  m_data;
  logic [7:0]  m_cnt;
  logic [3:0]  m_gnt;
  logic        m_valid;

  logic_op_arbiter #(.W(8)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .op(op), .a_in(a_in), .b_in(b_in),
    .gnt(gnt), .res_valid(res_valid), .res_id(res_id), .res_data(res_data),
    .res_ready(res_ready), .busy(busy), .done_cnt(done_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] calc(input logic [1:0] o, input logic [7:0] a, input logic [7:0] b);
    case (o)
      2'd0:    return ~a;
      2'd1:    return a & b;
      2'd2:    return a | b;
      default: return a ^ b;
    endcase
  endfunction

  function automatic int rr_pick(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++) begin
      if (r[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_opnd(input int i, input logic [1:0] o, input logic [7:0] a, input logic [7:0] b);
    op[2*i +: 2]  = o;
    a_in[8*i +: 8] = a;
    b_in[8*i +: 8] = b;
  endtask

  task automatic rand_opnd(input int i);
    set_opnd(i, 2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    m_phase = 0; m_ptr = 2'd0; m_id = 2'd0; m_data = 8'd0; m_cnt = 8'd0;
    m_gnt = 4'd0; m_valid = 1'b0; m_lop = 2'd0; m_la = 8'd0; m_lb = 8'd0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; req = 4'd0; op = 8'd0; a_in = 32'd0; b_in = 32'd0; res_ready = 1'b1;
    #2 rst_n = 1'b0;
    #2;
    total++; if (gnt !== 4'd0)      begin bad++; $display("[TB] FAIL reset_gnt got=%b want=0000", gnt); end
    total++; if (res_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid got=%b want=0", res_valid); end
    total++; if (res_id !== 2'd0)    begin bad++; $display("[TB] FAIL reset_id got=%0d want=0", res_id); end
    total++; if (res_data !== 8'd0)  begin bad++; $display("[TB] FAIL reset_data got=%h want=00", res_data); end
    total++; if (busy !== 1'b0)      begin bad++; $display("[TB] FAIL reset_busy got=%b want=0", busy); end
    total++; if (done_cnt !== 8'd0)  begin bad++; $display("[TB] FAIL reset_cnt got=%0d want=0", done_cnt); end
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_single_not();
    set_opnd(0, 2'b00, 8'hA5, 8'($urandom));
    res_ready = 1'b1;
    req = 4'b0001;
    tick();
    total++; if (gnt !== 4'b0001) begin bad++; $display("[TB] FAIL not_gnt got=%b want=0001", gnt); end
    total++; if (busy !== 1'b1)   begin bad++; $display("[TB] FAIL not_busy got=%b want=1", busy); end
    total++; if (res_valid !== 1'b0) begin bad++; $display("[TB] FAIL not_early_valid got=%b want=0", res_valid); end
    req = 4'b0000;
    tick();
    total++; if (gnt !== 4'b0000)    begin bad++; $display("[TB] FAIL not_gnt_clear got=%b want=0000", gnt); end
    total++; if (res_valid !== 1'b1) begin bad++; $display("[TB] FAIL not_valid got=%b want=1", res_valid); end
    total++; if (res_id !== 2'd0)    begin bad++; $display("[TB] FAIL not_id got=%0d want=0", res_id); end
    total++; if (res_data !== 8'h5A) begin bad++; $display("[TB] FAIL not_data got=%h want=5a", res_data); end
    tick();
    total++; if (res_valid !== 1'b0) begin bad++; $display("[TB] FAIL not_valid_clear got=%b want=0", res_valid); end
    total++; if (done_cnt !== 8'd1)  begin bad++; $display("[TB] FAIL not_cnt got=%0d want=1", done_cnt); end
    total++; if (busy !== 1'b0)      begin bad++; $display("[TB] FAIL not_idle got=%b want=0", busy); end
  endtask

  task automatic test_fairness();
    logic [3:0] exp_g;
    int w;
    do_reset();
    for (int i = 0; i < 4; i++) rand_opnd(i);
    res_ready = 1'b1;
    req = 4'b1111;
    for (int c = 0; c < 15; c++) begin
      tick();
      w = (c / 3) % 4;
      exp_g = 4'd0;
      if (c % 3 == 0) exp_g[w] = 1'b1;
      total++; if (gnt !== exp_g) begin bad++; $display("[TB] FAIL fair_gnt cyc=%0d got=%b want=%b", c, gnt, exp_g); end
      if (c % 3 == 1) begin
        total++;
        if (res_valid !== 1'b1 || res_data !== calc(op[2*w +: 2], a_in[8*w +: 8], b_in[8*w +: 8])) begin
          bad++;
          $display("[TB] FAIL fair_data cyc=%0d got=%b/%h want=1/%h", c, res_valid, res_data,
                   calc(op[2*w +: 2], a_in[8*w +: 8], b_in[8*w +: 8]));
        end
      end
    end
    req = 4'd0;
  endtask

  task automatic test_ops();
    do_reset();
    res_ready = 1'b1;
    set_opnd(2, 2'b11, 8'hF0, 8'h3C);
    set_opnd(3, 2'b01, 8'hF0, 8'h3C);
    set_opnd(1, 2'b10, 8'hF0, 8'h3C);
    req = 4'b0100;
    tick();
    total++; if (gnt !== 4'b0100 || res_id !== 2'd2) begin bad++; $display("[TB] FAIL xor_gnt got=%b/%0d want=0100/2", gnt, res_id); end
    req = 4'b0000;
    tick();
    total++; if (res_data !== 8'hCC || res_id !== 2'd2) begin bad++; $display("[TB] FAIL xor_data got=%h/%0d want=cc/2", res_data, res_id); end
    tick();
    req = 4'b1010;
    tick();
    total++; if (gnt !== 4'b1000) begin bad++; $display("[TB] FAIL rr_after_2 got=%b want=1000", gnt); end
    req = 4'b0010;
    tick();
    total++; if (res_data !== 8'h30 || res_id !== 2'd3) begin bad++; $display("[TB] FAIL and_data got=%h/%0d want=30/3", res_data, res_id); end
    tick();
    tick();
    total++; if (gnt !== 4'b0010) begin bad++; $display("[TB] FAIL rr_after_3 got=%b want=0010", gnt); end
    req = 4'b0000;
    tick();
    total++; if (res_data !== 8'hFC || res_id !== 2'd1) begin bad++; $display("[TB] FAIL or_data got=%h/%0d want=fc/1", res_data, res_id); end
    tick();
    total++; if (done_cnt !== 8'd3) begin bad++; $display("[TB] FAIL ops_cnt got=%0d want=3", done_cnt); end
  endtask

  task automatic test_backpressure();
    logic [7:0] exp_d;
    do_reset();
    for (int i = 0; i < 4; i++) rand_opnd(i);
    exp_d = calc(op[1:0], a_in[7:0], b_in[7:0]);
    res_ready = 1'b0;
    req = 4'b0001;
    tick();
    total++; if (gnt !== 4'b0001) begin bad++; $display("[TB] FAIL bp_gnt got=%b want=0001", gnt); end
    req = 4'b0110;
    tick();
    total++; if (res_valid !== 1'b1 || res_data !== exp_d) begin bad++; $display("[TB] FAIL bp_first got=%b/%h want=1/%h", res_valid, res_data, exp_d); end
    for (int c = 0; c < 5; c++) begin
      tick();
      total++;
      if (res_valid !== 1'b1 || res_id !== 2'd0 || res_data !== exp_d || gnt !== 4'd0 || busy !== 1'b1) begin
        bad++;
        $display("[TB] FAIL bp_hold cyc=%0d got=v%b id%0d d%h g%b b%b want=v1 id0 d%h g0000 b1",
                 c, res_valid, res_id, res_data, gnt, busy, exp_d);
      end
    end
    res_ready = 1'b1;
    tick();
    total++; if (res_valid !== 1'b0 || busy !== 1'b0 || done_cnt !== 8'd1) begin bad++; $display("[TB] FAIL bp_release got=v%b b%b c%0d want=v0 b0 c1", res_valid, busy, done_cnt); end
    tick();
    total++; if (gnt !== 4'b0010) begin bad++; $display("[TB] FAIL bp_next_gnt got=%b want=0010", gnt); end
    req = 4'd0;
    tick();
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    rand_opnd(0);
    res_ready = 1'b1;
    req = 4'b0001;
    tick();
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (gnt !== 4'd0 || res_valid !== 1'b0 || done_cnt !== 8'd0 || busy !== 1'b0 || res_data !== 8'd0) begin
      bad++;
      $display("[TB] FAIL midreset got=g%b v%b c%0d b%b d%h want=g0000 v0 c0 b0 d00", gnt, res_valid, done_cnt, busy, res_data);
    end
    req = 4'b0100;
    #1 rst_n = 1'b1;
    tick();
    total++; if (gnt !== 4'b0100) begin bad++; $display("[TB] FAIL midreset_first got=%b want=0100", gnt); end
    req = 4'd0;
    tick();
    tick();
    total++; if (done_cnt !== 8'd1) begin bad++; $display("[TB] FAIL midreset_cnt got=%0d want=1", done_cnt); end
  endtask

  task automatic test_random();
    int w;
    do_reset();
    req = 4'd0;
    for (int i = 0; i < 4; i++) rand_opnd(i);
    res_ready = 1'b1;
    for (int c = 0; c < 400; c++) begin
      // advance the model with the inputs present at this edge
      if (m_phase == 0) begin
        m_gnt = 4'd0;
        if (req != 4'd0) begin
          w = rr_pick(req, int'(m_ptr));
          m_gnt[w] = 1'b1;
          m_id  = 2'(w);
          m_lop = op[2*w +: 2];
          m_la  = a_in[8*w +: 8];
          m_lb  = b_in[8*w +: 8];
          m_phase = 1;
        end
      end else if (m_phase == 1) begin
        m_gnt = 4'd0;
        m_data = calc(m_lop, m_la, m_lb);
        m_valid = 1'b1;
        m_phase = 2;
      end else if (res_ready) begin
        m_valid = 1'b0;
        m_ptr = m_id + 2'd1;
        m_cnt = m_cnt + 8'd1;
        m_phase = 0;
      end
      tick();
      total++; if (gnt !== m_gnt)        begin bad++; $display("[TB] FAIL rand_gnt cyc=%0d got=%b want=%b", c, gnt, m_gnt); end
      total++; if (res_valid !== m_valid) begin bad++; $display("[TB] FAIL rand_valid cyc=%0d got=%b want=%b", c, res_valid, m_valid); end
      total++; if (res_id !== m_id)      begin bad++; $display("[TB] FAIL rand_id cyc=%0d got=%0d want=%0d", c, res_id, m_id); end
      total++; if (res_data !== m_data)  begin bad++; $display("[TB] FAIL rand_data cyc=%0d got=%h want=%h", c, res_data, m_data); end
      total++; if (busy !== (m_phase != 0)) begin bad++; $display("[TB] FAIL rand_busy cyc=%0d got=%b want=%b", c, busy, m_phase != 0); end
      total++; if (done_cnt !== m_cnt)   begin bad++; $display("[TB] FAIL rand_cnt cyc=%0d got=%0d want=%0d", c, done_cnt, m_cnt); end
      // granted requesters may drop or re-request; operands change right
      // after the grant to prove the in-flight result was latched
      for (int i = 0; i < 4; i++) begin
        if (m_gnt[i]) begin
          if ($urandom_range(0, 3) != 0) req[i] = 1'b0;
          rand_opnd(i);
        end else if (!req[i] && $urandom_range(0, 2) == 0) begin
          rand_opnd(i);
          req[i] = 1'b1;
        end
      end
      res_ready = ($urandom_range(0, 3) != 0);
    end
    req = 4'd0;
  endtask

  task automatic test_wrap();
    do_reset();
    rand_opnd(0);
    res_ready = 1'b1;
    req = 4'b0001;
    repeat (765) tick();
    total++; if (done_cnt !== 8'd255) begin bad++; $display("[TB] FAIL wrap_255 got=%0d want=255", done_cnt); end
    repeat (3) tick();
    total++; if (done_cnt !== 8'd0) begin bad++; $display("[TB] FAIL wrap_0 got=%0d want=0", done_cnt); end
    req = 4'd0;
  endtask

  initial begin
    $display("[TB] starting logic_op_arbiter bench");
    test_reset();
    test_single_not();
    test_fairness();
    test_ops();
    test_backpressure();
    test_reset_mid();
    test_random();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
